player_ctrl: RTL

- Parametrised player-side controller for the Space Invaders core: ship position, a pool of bullet slots, score, lives and a game-phase FSM.
- Inputs are single-cycle pulses from upstream debouncers.
- Sits between the input debouncers and the collision/video logic.
- Generalises the single-bullet player with configurable widths, multiple simultaneous bullets, fire cooldown, lives and saturating score.

---
 rtl/player_pkg.sv | 16 +
 rtl/player_ctrl_if.sv | 35 +++
 rtl/bullet_slot.sv | 63 ++++++
 rtl/player_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
`default_nettype none
// ---- player_pkg : shared phase encoding and widths for the player controller ----
// Rev 1.0
package player_pkg;

    localparam int LIVES_W = 3;

    typedef enum logic [1:0] {
        PH_IDLE      = 2'd0,
        PH_PLAYING   = 2'd1,
        PH_DYING     = 2'd2,
        PH_GAME_OVER = 2'd3
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/player_ctrl_if.sv
`default_nettype none
// ---- player_ctrl_if : debounced player inputs and ship/bullet/score outputs ----
// Rev 1.0
interface player_ctrl_if #(
    parameter int X_W       = 5,
    parameter int Y_W       = 4,
    parameter int N_BULLETS = 3,
    parameter int SCORE_W   = 8
);
    logic                          tick;
    logic                          left;
    logic                          right;
    logic                          shoot;
    logic                          start;
    logic [N_BULLETS-1:0]          hit;
    logic                          player_hit;
    logic [X_W-1:0]                ship_x;
    logic [N_BULLETS*X_W-1:0]      bullet_x;
    logic [N_BULLETS*Y_W-1:0]      bullet_y;
    logic [N_BULLETS-1:0]          bullet_flying;
    logic [SCORE_W-1:0]            score;
    logic [player_pkg::LIVES_W-1:0] lives;
    logic [1:0]                    phase;

    modport master (
        output tick, left, right, shoot, start, hit, player_hit,
        input  ship_x, bullet_x, bullet_y, bullet_flying, score, lives, phase
    );

    modport slave (
        input  tick, left, right, shoot, start, hit, player_hit,
        output ship_x, bullet_x, bullet_y, bullet_flying, score, lives, phase
    );
endinterface
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ---- bullet_slot : one bullet's position and flying flag ----
// Rev 1.0
module bullet_slot #(
    parameter int X_W = 5,
    parameter int Y_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear_i,
    input  logic           launch_i,
    input  logic [X_W-1:0] launch_x_i,
    input  logic           tick_i,
    input  logic           hit_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           flying_o
);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           flying_q, flying_d;

    // Priority: wipe > launch > hit > tick advance; a fresh launch never advances.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        flying_d = flying_q;
        if (clear_i) begin
            x_d      = '0;
            y_d      = '0;
            flying_d = 1'b0;
        end else if (launch_i) begin
            x_d      = launch_x_i;
            y_d      = '1;
            flying_d = 1'b1;
        end else if (flying_q && hit_i) begin
            flying_d = 1'b0;
        end else if (flying_q && tick_i) begin
            if (y_q == '0) begin
                flying_d = 1'b0;
            end else begin
                y_d = y_q - Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            flying_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            flying_q <= flying_d;
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign flying_o = flying_q;
endmodule
`default_nettype wire

// File: rtl/player_ctrl.sv
`default_nettype none
// ---- player_ctrl : ship, bullet pool, score, lives and game-phase FSM ----
// Optional macro PLAYER_BONUS_LIFE_EN: one bonus life per game at score 2^(SCORE_W-2). Rev 1.0
module player_ctrl
    import player_pkg::*;
#(
    parameter int X_W           = 5,
    parameter int Y_W           = 4,
    parameter int N_BULLETS     = 3,
    parameter int SCORE_W       = 8,
    parameter int LIVES         = 3,
    parameter int COOLDOWN      = 2,
    parameter int RESPAWN_TICKS = 16
) (
    input  logic         clk_36MHz,
    input  logic         reset,
    player_ctrl_if.slave bus
);
    localparam logic [X_W-1:0] X_MAX = {X_W{1'b1}};
    localparam logic [X_W-1:0] X_MID = X_MAX >> 1;
    localparam int             CD_W  = $clog2(COOLDOWN + 2);
    localparam int             RS_W  = $clog2(RESPAWN_TICKS + 2);

    phase_e               phase_q, phase_d;
    logic [X_W-1:0]       ship_x_q, ship_x_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [CD_W-1:0]      cooldown_q, cooldown_d;
    logic [RS_W-1:0]      respawn_q, respawn_d;

    logic [N_BULLETS-1:0]     flying, free_onehot, launch, hit_valid;
    logic [N_BULLETS*X_W-1:0] bullet_x;
    logic [N_BULLETS*Y_W-1:0] bullet_y;
    logic                     any_free, playing, shot_ok, start_game, crash, clear_all;
    logic [3:0]               n_hits;
    logic [SCORE_W:0]         score_sum;

    assign playing    = (phase_q == PH_PLAYING);
    assign start_game = bus.start && (phase_q == PH_IDLE || phase_q == PH_GAME_OVER);
    assign crash      = playing && bus.player_hit;
    assign clear_all  = start_game || crash;
    assign hit_valid  = bus.hit & flying;

    always_comb begin
        free_onehot = '0;
        any_free    = 1'b0;
        n_hits      = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!flying[i] && !any_free) begin
                free_onehot[i] = 1'b1;
                any_free       = 1'b1;
            end
            n_hits = n_hits + 4'(hit_valid[i]);
        end
    end

    assign shot_ok   = playing && bus.shoot && !bus.player_hit && (cooldown_q == '0) && any_free;
    assign launch    = shot_ok ? free_onehot : '0;
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(n_hits);

    for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
        bullet_slot #(.X_W(X_W), .Y_W(Y_W)) u_slot (
            .clk        (clk_36MHz),
            .rst_n      (reset),
            .clear_i    (clear_all),
            .launch_i   (launch[i]),
            .launch_x_i (ship_x_q),
            .tick_i     (bus.tick),
            .hit_i      (bus.hit[i]),
            .x_o        (bullet_x[i*X_W +: X_W]),
            .y_o        (bullet_y[i*Y_W +: Y_W]),
            .flying_o   (flying[i])
        );
    end

`ifdef PLAYER_BONUS_LIFE_EN
    localparam logic [SCORE_W-1:0] BONUS_TH = SCORE_W'(1) << (SCORE_W - 2);
    logic bonus_q, bonus_d;
`endif

    always_comb begin
        phase_d    = phase_q;
        ship_x_d   = ship_x_q;
        score_d    = score_q;
        lives_d    = lives_q;
        cooldown_d = cooldown_q;
        respawn_d  = respawn_q;
`ifdef PLAYER_BONUS_LIFE_EN
        bonus_d    = bonus_q;
`endif
        if (bus.tick && cooldown_q != '0) cooldown_d = cooldown_q - CD_W'(1);

        case (phase_q)
            PH_IDLE, PH_GAME_OVER: begin
                if (bus.start) begin
                    phase_d    = PH_PLAYING;
                    ship_x_d   = X_MID;
                    score_d    = '0;
                    lives_d    = LIVES_W'(LIVES);
                    cooldown_d = '0;
`ifdef PLAYER_BONUS_LIFE_EN
                    bonus_d    = 1'b0;
`endif
                end
            end
            PH_PLAYING: begin
                // Moves use the pre-move ship_x, which also feeds the launching slot.
                if (bus.left && !bus.right && ship_x_q != '0)
                    ship_x_d = ship_x_q - X_W'(1);
                else if (bus.right && !bus.left && ship_x_q != X_MAX)
                    ship_x_d = ship_x_q + X_W'(1);
                if (shot_ok) cooldown_d = CD_W'(COOLDOWN);
                score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                if (bus.player_hit) begin
                    phase_d   = PH_DYING;
                    respawn_d = RS_W'(RESPAWN_TICKS);
                    if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
                end
            end
            PH_DYING: begin
                if (bus.tick) begin
                    if (respawn_q <= RS_W'(1)) begin
                        respawn_d = '0;
                        if (lives_q != '0) begin
                            phase_d  = PH_PLAYING;
                            ship_x_d = X_MID;
                        end else begin
                            phase_d  = PH_GAME_OVER;
                        end
                    end else begin
                        respawn_d = respawn_q - RS_W'(1);
                    end
                end
            end
            default: phase_d = PH_IDLE;
        endcase

`ifdef PLAYER_BONUS_LIFE_EN
        if (playing && !bonus_q && score_q < BONUS_TH && score_d >= BONUS_TH) begin
            bonus_d = 1'b1;
            if (lives_d != {LIVES_W{1'b1}}) lives_d = lives_d + LIVES_W'(1);
        end
`endif
    end

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            phase_q    <= PH_IDLE;
            ship_x_q   <= X_MID;
            score_q    <= '0;
            lives_q    <= LIVES_W'(LIVES);
            cooldown_q <= '0;
            respawn_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            ship_x_q   <= ship_x_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            cooldown_q <= cooldown_d;
            respawn_q  <= respawn_d;
        end
    end

`ifdef PLAYER_BONUS_LIFE_EN
    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) bonus_q <= 1'b0;
        else        bonus_q <= bonus_d;
    end
`endif

    assign bus.ship_x        = ship_x_q;
    assign bus.bullet_x      = bullet_x;
    assign bus.bullet_y      = bullet_y;
    assign bus.bullet_flying = flying;
    assign bus.score         = score_q;
    assign bus.lives         = lives_q;
    assign bus.phase         = phase_q;
endmodule
`default_nettype wire
